// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with valid/ready grant handshake.
// A strict thermometer above the last served index picks the next winner.
module rr_arbiter #(
    parameter  int WIDTH          = 8,
    parameter  int SPLIT          = 2,
    parameter  int IMPLEMENTATION = 0,
    localparam int IDX_W          = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld,
    input  logic             rdy
);

    function automatic int pad_w(int w, int s);
        int p;
        p = 1;
        if (s < 2) return w;
        while (p < w) p = p * s;
        return p;
    endfunction

    localparam int PW = pad_w(WIDTH, SPLIT);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic             vld_q, vld_d;

    logic             xfer;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] win_idx;
    logic [PW-1:0]    req_p;
    logic [PW-1:0]    sh;
    logic [PW-1:0]    msk;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    lsb;

    assign xfer  = vld_q & rdy;
    // On a transfer the mask follows the grant being retired, not ptr_q.
    assign base  = xfer ? idx_q : ptr_q;
    assign req_p = PW'(req);
    assign sh    = (PW'(1) << base) << 1;
    assign msk   = ~(sh - PW'(1));
    assign cand  = (|(req_p & msk)) ? (req_p & msk) : req_p;

    generate
        if (IMPLEMENTATION == 0) begin : g_lsb_loop
            always_comb begin
                logic found;
                found = 1'b0;
                lsb   = '0;
                for (int i = 0; i < PW; i++) begin
                    if (cand[i] && !found) begin
                        lsb[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end else begin : g_lsb_arith
            assign lsb = cand & (~cand + PW'(1));
        end
    endgenerate

    // Padded request bits are tied low, so lsb above WIDTH-1 is always zero.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < PW; i++) begin
            if (lsb[i]) win_idx = win_idx | IDX_W'(i);
        end
    end

    always_comb begin
        ptr_d = xfer ? idx_q : ptr_q;
        gnt_d = gnt_q;
        idx_d = idx_q;
        vld_d = vld_q;
        if (!vld_q || rdy) begin
            gnt_d = lsb[WIDTH-1:0];
            idx_d = win_idx;
            vld_d = |req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(WIDTH - 1);
            idx_q <= '0;
            gnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            gnt_q <= gnt_d;
            vld_q <= vld_d;
        end
    end

    assign gnt = gnt_q;
    assign idx = idx_q;
    assign vld = vld_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: 8-wide instance plus a 5-wide padded one.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       rdy = 1'b0;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;

    logic [4:0] req5 = '0;
    logic       rdy5 = 1'b0;
    logic [4:0] gnt5;
    logic [2:0] idx5;
    logic       vld5;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .idx   (idx),
        .vld   (vld),
        .rdy   (rdy)
    );

    rr_arbiter #(.WIDTH(5), .SPLIT(2), .IMPLEMENTATION(1)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req5),
        .gnt   (gnt5),
        .idx   (idx5),
        .vld   (vld5),
        .rdy   (rdy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values
        tick();
        tick();
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_vld", 32'(vld), 32'd0);

        // first grant goes to lowest requester
        req = 8'b0010_0100;
        tick();
        chk("first_gnt", 32'(gnt), 32'h04);
        chk("first_idx", 32'(idx), 32'd2);
        chk("first_vld", 32'(vld), 32'd1);

        // drain to idle
        req = '0;
        rdy = 1'b1;
        tick();
        chk("drain_vld", 32'(vld), 32'd0);
        chk("drain_gnt", 32'(gnt), 32'd0);

        // reset while idle restores ptr, then full rotation
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 8'hFF;
        rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("rot_idx%0d", k), 32'(idx), 32'(k % 8));
            chk($sformatf("rot_vld%0d", k), 32'(vld), 32'd1);
            chk($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(8'd1 << (k % 8)));
        end
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_idx", 32'(idx), 32'd5);

        // async reset mid-grant
        rdy = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_vld", 32'(vld), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_idx", 32'(idx), 32'd0);
        chk("async_vld5", 32'(vld5), 32'd0);
        rst_n = 1'b1;
        rdy = 1'b1;
        tick();
        chk("post_rst_idx", 32'(idx), 32'd0);

        // lock under backpressure
        tick();
        tick();
        tick();
        chk("lock_start_idx", 32'(idx), 32'd3);
        rdy = 1'b0;
        req = 8'b0000_0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("lock_gnt%0d", k), 32'(gnt), 32'h08);
            chk($sformatf("lock_vld%0d", k), 32'(vld), 32'd1);
        end
        rdy = 1'b1;
        tick();
        chk("unlock_idx", 32'(idx), 32'd0);

        // fairness with skipping
        req = 8'b1000_0010;
        tick();
        chk("fair_idx0", 32'(idx), 32'd1);
        tick();
        chk("fair_idx1", 32'(idx), 32'd7);
        tick();
        chk("fair_idx2", 32'(idx), 32'd1);
        tick();
        chk("fair_idx3", 32'(idx), 32'd7);
        chk("fair_gnt3", 32'(gnt), 32'h80);
        req = '0;
        tick();
        chk("fair_end_vld", 32'(vld), 32'd0);
        chk("fair_end_gnt", 32'(gnt), 32'd0);
        chk("fair_end_idx", 32'(idx), 32'd0);

        // odd width, padded tree
        req5 = 5'b10001;
        rdy5 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("w5_idx%0d", k), 32'(idx5), (k % 2 == 0) ? 32'd0 : 32'd4);
            chk($sformatf("w5_gnt%0d", k), 32'(gnt5),
                (k % 2 == 0) ? 32'h01 : 32'h10);
            chk($sformatf("w5_range%0d", k), 32'(idx5 <= 3'd4), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
